sram_is61wv25616_controller_param: RTL

//  Parametrised IS61WV25616 (256K x 16) SRAM controller: moves DATA_W-bit words as DATA_W/16 half-word beats.

---
 rtl/sram_ctrl_pkg.sv | 28 ++
 rtl/sram_ctrl_beat_timer.sv | 64 ++++++
 rtl/sram_is61wv25616_controller_param.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the IS61WV25616 SRAM controller:
//   sram_state_e  controller FSM state encoding (3 bits)
//   SRAM_DQ_W     SRAM data bus width (16)
//   SRAM_ADDR_W   SRAM half-word address width (18)
//   WAIT_W        width of the per-beat wait-state count (0..7)
//   beat_bits()   width of a beat index, never less than 1
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int SRAM_DQ_W   = 16;
    localparam int SRAM_ADDR_W = 18;
    localparam int WAIT_W      = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRead  = 3'd2,
        StAck   = 3'd3
    } sram_state_e;

    // A single-beat controller still needs a 1-bit index vector.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_ctrl_beat_timer
// Wait-state and beat counter for the SRAM controller. Each beat lasts
// 1+wait_cycles cycles while 'active' is high.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   start            restart at beat 0, wait 0 (transaction accepted)
//   active           controller is in a read or write state
//   wait_cycles      extra cycles per beat for the current access
//   beat             index of the current beat
//   beat_last_cycle  this cycle is the final cycle of the current beat
//   xfer_done        final cycle of the final beat
// ---------------------------------------------------------------------------
module sram_ctrl_beat_timer
    import sram_ctrl_pkg::*;
#(
    parameter int BEATS = 2,
    parameter int BW    = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              start,
    input  logic              active,
    input  logic [WAIT_W-1:0] wait_cycles,
    output logic [BW-1:0]     beat,
    output logic              beat_last_cycle,
    output logic              xfer_done
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [BW-1:0]     beat_reg, beat_next;

    assign beat_last_cycle = active && (wait_reg == wait_cycles);
    assign xfer_done       = beat_last_cycle && (beat_reg == LAST_BEAT);
    assign beat            = beat_reg;

    always_comb begin
        wait_next = wait_reg;
        beat_next = beat_reg;
        if (start) begin
            wait_next = '0;
            beat_next = '0;
        end else if (beat_last_cycle) begin
            wait_next = '0;
            // Wrap after the last beat so an idle timer always sits at 0.
            beat_next = xfer_done ? '0 : beat_reg + 1'b1;
        end else if (active) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_reg <= '0;
            beat_reg <= '0;
        end else begin
            wait_reg <= wait_next;
            beat_reg <= beat_next;
        end
    end

endmodule

// File: rtl/sram_is61wv25616_controller_param.sv
// ---------------------------------------------------------------------------
// sram_is61wv25616_controller_param
// IS61WV25616 (256K x 16) asynchronous SRAM controller. A DATA_W-bit word is
// moved as DATA_W/16 half-word beats, each lasting 1+RD_WAIT or 1+WR_WAIT
// cycles. Requests use a ready/valid handshake; o_ACK pulses once per
// completed transaction.
//
// Optional feature macro: SRAM_CTRL_ERR_EN
//   defined   : both enables high, or a misaligned request, is dropped and
//               pulses o_ERR for one cycle.
//   undefined : o_ERR is 0, misaligned addresses are aligned silently and
//               both-enable requests are ignored.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_ADDR [17:0]          half-word address (low log2(BEATS) bits dropped)
//   i_WDATA [DATA_W-1:0]   write data, beat k = bits [16k+15:16k]
//   i_BMASK [DATA_W/8-1:0] byte enables, beat k = bits [2k+1:2k]
//   i_WREN, i_RDEN         write / read request
//   o_READY                request accepted when high
//   o_RDATA                last completed read word
//   o_ACK, o_ERR           one-cycle completion / error pulses
//   SRAM_*                 SRAM pins (DQ driven only while writing)
// ---------------------------------------------------------------------------
module sram_is61wv25616_controller_param
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 0,
    parameter int WR_WAIT = 0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [SRAM_ADDR_W-1:0] i_ADDR,
    input  logic [DATA_W-1:0]      i_WDATA,
    input  logic [DATA_W/8-1:0]    i_BMASK,
    input  logic                   i_WREN,
    input  logic                   i_RDEN,
    output logic                   o_READY,
    output logic [DATA_W-1:0]      o_RDATA,
    output logic                   o_ACK,
    output logic                   o_ERR,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_UB_N
);

    localparam int BEATS      = DATA_W / 16;
    localparam int BW         = beat_bits(BEATS);
    localparam int ALIGN_BITS = $clog2(BEATS);
    // Address bits that select a beat inside a word; zero for BEATS=1.
    localparam logic [SRAM_ADDR_W-1:0] ADDR_LOW  = SRAM_ADDR_W'((1 << ALIGN_BITS) - 1);
    localparam logic [WAIT_W-1:0]      RD_WAIT_C = WAIT_W'(RD_WAIT);
    localparam logic [WAIT_W-1:0]      WR_WAIT_C = WAIT_W'(WR_WAIT);

    sram_state_e              state_reg, state_next;
    logic [SRAM_ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]        wdata_reg, wdata_next;
    logic [DATA_W/8-1:0]      bmask_reg, bmask_next;
    logic [DATA_W-1:0]        rdata_reg;
    logic [DATA_W-1:0]        rd_buf_reg;
    logic [DATA_W-1:0]        rd_word;

    logic                     busy;
    logic                     req_one;
    logic                     accept;
    logic [WAIT_W-1:0]        wait_sel;
    logic [BW-1:0]            beat_idx;
    logic                     beat_last;
    logic                     xfer_done;
    logic [SRAM_DQ_W-1:0]     dq_out;
    logic [1:0]               beat_mask;

    assign busy     = (state_reg == StWrite) || (state_reg == StRead);
    assign o_READY  = (state_reg == StIdle) || (state_reg == StAck);
    assign req_one  = i_WREN ^ i_RDEN;
    assign wait_sel = (state_reg == StWrite) ? WR_WAIT_C : RD_WAIT_C;

`ifdef SRAM_CTRL_ERR_EN
    logic misaligned;
    logic err_reg;

    assign misaligned = |(i_ADDR & ADDR_LOW);
    assign accept     = o_READY && req_one && !misaligned;
    assign o_ERR      = err_reg;

    // Registered so the pulse is exactly one cycle wide after the bad request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            err_reg <= 1'b0;
        else
            err_reg <= o_READY && ((i_WREN && i_RDEN) || (req_one && misaligned));
    end
`else
    assign accept = o_READY && req_one;
    assign o_ERR  = 1'b0;
`endif

    sram_ctrl_beat_timer #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_beat_timer (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .start           (accept),
        .active          (busy),
        .wait_cycles     (wait_sel),
        .beat            (beat_idx),
        .beat_last_cycle (beat_last),
        .xfer_done       (xfer_done)
    );

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        bmask_next = bmask_reg;
        case (state_reg)
            StIdle, StAck: begin
                if (accept) begin
                    state_next = i_WREN ? StWrite : StRead;
                    addr_next  = i_ADDR & ~ADDR_LOW;
                    wdata_next = i_WDATA;
                    bmask_next = i_BMASK;
                end else begin
                    state_next = StIdle;
                end
            end
            StWrite: if (xfer_done) state_next = StIdle;
            StRead:  if (xfer_done) state_next = StAck;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= StIdle;
            addr_reg  <= '0;
            wdata_reg <= '0;
            bmask_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            bmask_reg <= bmask_next;
        end
    end

    // ---------------------------------------------------------- read path
    // Earlier beats are parked in rd_buf_reg; the final beat is taken straight
    // from DQ so o_RDATA only changes when a whole word is complete.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_rd_word
        assign rd_word[16*gi +: 16] = (beat_idx == BW'(gi)) ? SRAM_DQ
                                                             : rd_buf_reg[16*gi +: 16];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_buf_reg <= '0;
            rdata_reg  <= '0;
        end else if (state_reg == StRead && beat_last) begin
            rd_buf_reg <= rd_word;
            if (xfer_done)
                rdata_reg <= rd_word;
        end
    end

    assign o_RDATA = rdata_reg;
    assign o_ACK   = (state_reg == StAck) || (state_reg == StWrite && xfer_done);

    // ---------------------------------------------------------- SRAM pins
    always_comb begin
        dq_out    = '0;
        beat_mask = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_idx == BW'(i)) begin
                dq_out    = wdata_reg[16*i +: 16];
                beat_mask = bmask_reg[2*i +: 2];
            end
        end
    end

    assign SRAM_ADDR = addr_reg | SRAM_ADDR_W'(beat_idx);
    assign SRAM_CE_N = (state_reg == StIdle);
    assign SRAM_WE_N = (state_reg != StWrite);
    assign SRAM_OE_N = (state_reg != StRead);
    assign SRAM_LB_N = !(busy && beat_mask[0]);
    assign SRAM_UB_N = !(busy && beat_mask[1]);
    assign SRAM_DQ   = (state_reg == StWrite) ? dq_out : 'z;

endmodule
